// File: rtl/fifotx.sv
// fifotx: drains words from an upstream single-clock FIFO and sends each one
// as an asynchronous serial frame: start bit, DATA_WIDTH data bits LSB first,
// STOP_BITS stop bits, every bit held CLKS_PER_BIT clocks.
//
// Handshake with the FIFO: remove is a combinational pop strobe, raised only
// in IDLE while enable is high and the FIFO is not empty. The FIFO accepts the
// pop on that same rising edge and presents the word on fifo_do during the
// following cycle (LOAD), where it is captured into the shift register.
module fifotx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    output logic                  remove,
    output logic                  txd,
    output logic                  busy,
    output logic                  done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [BAUD_W-1:0]     baud;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  bit_end;
    logic                  last_data;
    logic                  last_stop;
    logic                  stop_penult;

    // The bit counter is reused in STOP to index the stop bits.
    assign bit_end     = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_data   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign last_stop   = (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign stop_penult = (baud == BAUD_W'(CLKS_PER_BIT - 2));
    assign shift_nxt   = shift >> 1;

    // Pop strobe and next-state decode.
    always_comb begin
        remove    = 1'b0;
        state_nxt = state;
        if (state == IDLE && enable && !empty && !flush) begin
            remove = 1'b1;
        end
        case (state)
            IDLE:    if (remove) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && last_data) state_nxt = STOP;
            STOP:    if (bit_end && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the registered line, status and counters.
    always_ff @(posedge clk) begin
        if (flush) begin
            state   <= IDLE;
            txd     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                end
                LOAD: begin
                    shift   <= fifo_do;
                    baud    <= '0;
                    bit_cnt <= '0;
                    txd     <= 1'b0;
                    busy    <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        txd     <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud  <= '0;
                        shift <= shift_nxt;
                        if (last_data) begin
                            bit_cnt <= '0;
                            txd     <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            txd     <= shift_nxt[0];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    // done is registered, so raise it one cycle ahead of the
                    // final stop cycle; CLKS_PER_BIT >= 2 keeps that inside STOP.
                    if (last_stop && stop_penult) begin
                        done <= 1'b1;
                    end
                    if (bit_end) begin
                        baud <= '0;
                        if (last_stop) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifotx.sv
// Directed bench for fifotx: a default instance fed from a small word queue,
// and a second instance with CLKS_PER_BIT=3, STOP_BITS=2 fed one fixed word.
module tb_fifotx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       flush   = 1'b1;
    logic       enable  = 1'b0;
    logic       empty   = 1'b1;
    logic [3:0] fifo_do = 4'h0;
    logic       remove, txd, busy, done;

    logic       enable2  = 1'b0;
    logic       empty2   = 1'b1;
    logic [3:0] fifo_do2 = 4'h5;
    logic       remove2, txd2, busy2, done2;

    fifotx dut (
        .clk(clk), .flush(flush), .enable(enable), .empty(empty),
        .fifo_do(fifo_do), .remove(remove), .txd(txd), .busy(busy), .done(done)
    );

    fifotx #(.DATA_WIDTH(4), .CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
        .clk(clk), .flush(flush), .enable(enable2), .empty(empty2),
        .fifo_do(fifo_do2), .remove(remove2), .txd(txd2), .busy(busy2), .done(done2)
    );

    localparam int LOG_N = 2048;

    logic [3:0] fq[$];
    int         total = 0;
    int         bad   = 0;
    int         n     = 0;

    logic tx_log [0:LOG_N-1];
    logic bz_log [0:LOG_N-1];
    logic dn_log [0:LOG_N-1];
    logic rm_log [0:LOG_N-1];
    logic tx2_log[0:LOG_N-1];
    logic bz2_log[0:LOG_N-1];
    logic dn2_log[0:LOG_N-1];
    logic rm2_log[0:LOG_N-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, then model the FIFO pop.
    task automatic cyc();
        logic rm, rm2;
        @(negedge clk);
        rm  = remove;
        rm2 = remove2;
        if (n < LOG_N) begin
            tx_log[n]  = txd;   bz_log[n]  = busy;  dn_log[n]  = done;  rm_log[n]  = rm;
            tx2_log[n] = txd2;  bz2_log[n] = busy2; dn2_log[n] = done2; rm2_log[n] = rm2;
        end
        @(posedge clk);
        #1;
        n++;
        if (rm === 1'b1 && fq.size() > 0) fifo_do = fq.pop_front();
        if (rm2 === 1'b1) empty2 = 1'b1;
        empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [3:0] w);
        fq.push_back(w);
        empty = 1'b0;
    endtask

    // Expected line level k cycles into a frame (k=0 is the first start cycle).
    function automatic logic exp_bit(input logic [3:0] w, input int k, input int cpb);
        int b;
        b = k / cpb;
        if (b == 0) return 1'b0;
        if (b <= 4) return w[b-1];
        return 1'b1;
    endfunction

    task automatic wait_rm(input string tag, output int r, input int limit, input bit second);
        logic seen;
        r = -1;
        for (int i = 0; i < limit; i++) begin
            cyc();
            seen = second ? rm2_log[n-1] : rm_log[n-1];
            if (seen === 1'b1) begin
                r = n - 1;
                break;
            end
        end
        chk({tag, "_remove_seen"}, (r >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    function automatic int count_rm(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (rm_log[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic check_frame(input string tag, input logic [3:0] w, input int r,
                               input int cpb, input int stops, input bit second);
        int   len;
        int   idx;
        logic t, d, b;
        len = (5 + stops) * cpb;
        chk({tag, "_load_txd"}, second ? tx2_log[r+1] : tx_log[r+1], 1);
        for (int k = 0; k < len; k++) begin
            idx = r + 2 + k;
            t = second ? tx2_log[idx] : tx_log[idx];
            d = second ? dn2_log[idx] : dn_log[idx];
            b = second ? bz2_log[idx] : bz_log[idx];
            chk($sformatf("%s_txd_k%0d", tag, k), t, exp_bit(w, k, cpb));
            chk($sformatf("%s_done_k%0d", tag, k), d, (k == len - 1) ? 1 : 0);
            chk($sformatf("%s_busy_k%0d", tag, k), b, 1);
        end
        idx = r + 2 + len;
        chk({tag, "_busy_after"}, second ? bz2_log[idx] : bz_log[idx], 0);
        chk({tag, "_done_after"}, second ? dn2_log[idx] : dn_log[idx], 0);
        chk({tag, "_txd_after"}, second ? tx2_log[idx] : tx_log[idx], 1);
    endtask

    initial begin
        int r, r2, start, nrm, zc, dc;
        int rr[3];
        logic [3:0] words[3];
        logic [3:0] val;

        // Flush, then idle with an empty FIFO and enable high.
        flush = 1'b1;
        cyc(); cyc();
        flush  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("idle_txd_%0d", i), tx_log[n-1], 1);
            chk($sformatf("idle_busy_%0d", i), bz_log[n-1], 0);
            chk($sformatf("idle_done_%0d", i), dn_log[n-1], 0);
            chk($sformatf("idle_rm_%0d", i), rm_log[n-1], 0);
            chk($sformatf("idle2_txd_%0d", i), tx2_log[n-1], 1);
            chk($sformatf("idle2_rm_%0d", i), rm2_log[n-1], 0);
        end

        // Single word 0xA.
        push(4'hA);
        wait_rm("single", r, 5, 1'b0);
        if (r >= 0) begin
            while (n < r + 28) cyc();
            check_frame("single", 4'hA, r, 4, 1, 1'b0);
            chk("single_rm_count", count_rm(r + 1, r + 27), 0);
        end

        // Three preloaded words, back to back.
        enable = 1'b0;
        words[0] = 4'h1; words[1] = 4'hF; words[2] = 4'h6;
        push(words[0]); push(words[1]); push(words[2]);
        cyc(); cyc();
        enable = 1'b1;
        start = n;
        repeat (85) cyc();
        nrm = 0;
        for (int i = start; i < n; i++) begin
            if (rm_log[i] === 1'b1) begin
                if (nrm < 3) rr[nrm] = i;
                nrm++;
            end
        end
        chk("burst_rm_count", nrm, 3);
        if (nrm == 3) begin
            chk("burst_gap01", rr[1] - rr[0], 26);
            chk("burst_gap12", rr[2] - rr[1], 26);
            for (int f = 0; f < 3; f++) begin
                for (int j = 0; j < 4; j++) val[j] = tx_log[rr[f] + 2 + 4 * (j + 1) + 2];
                chk($sformatf("burst_word%0d", f), val, words[f]);
                check_frame($sformatf("burst%0d", f), words[f], rr[f], 4, 1, 1'b0);
            end
            for (int f = 0; f < 2; f++) begin
                zc = 0;
                for (int i = rr[f] + 2; i < rr[f+1] + 2; i++) if (bz_log[i] === 1'b0) zc++;
                chk($sformatf("burst_busy_gap%0d", f), zc, 2);
            end
            dc = 0;
            for (int i = start; i < n; i++) if (dn_log[i] === 1'b1) dc++;
            chk("burst_done_count", dc, 3);
        end

        // Enable dropped five cycles into a frame with another word pending.
        push(4'h3); push(4'hC);
        wait_rm("endrop", r, 5, 1'b0);
        if (r >= 0) begin
            while (n < r + 7) cyc();
            enable = 1'b0;
            while (n < r + 40) cyc();
            check_frame("endrop", 4'h3, r, 4, 1, 1'b0);
            chk("endrop_rm_hold", count_rm(r + 1, r + 39), 0);
            enable = 1'b1;
            cyc();
            chk("endrop_rm_resume", rm_log[n-1], 1);
            r2 = n - 1;
            while (n < r2 + 28) cyc();
            check_frame("endrop2", 4'hC, r2, 4, 1, 1'b0);
        end

        // Flush during data bit 2, then a clean frame.
        push(4'h9);
        wait_rm("flush", r, 5, 1'b0);
        if (r >= 0) begin
            while (n < r + 15) cyc();
            flush = 1'b1;
            fq.delete();
            cyc();
            flush = 1'b0;
            while (n < r + 20) cyc();
            chk("flush_bit2_txd", tx_log[r+14], 0);
            chk("flush_rm_low", rm_log[r+15], 0);
            chk("flush_txd_next", tx_log[r+16], 1);
            chk("flush_busy_next", bz_log[r+16], 0);
            dc = 0;
            for (int i = r + 15; i < n; i++) if (dn_log[i] === 1'b1) dc++;
            chk("flush_no_done", dc, 0);
            push(4'h5);
            wait_rm("postflush", r2, 5, 1'b0);
            if (r2 >= 0) begin
                while (n < r2 + 28) cyc();
                check_frame("postflush", 4'h5, r2, 4, 1, 1'b0);
            end
        end

        // Second instance: three clocks per bit, two stop bits, word 0x5.
        fifo_do2 = 4'h5;
        empty2   = 1'b0;
        enable2  = 1'b1;
        wait_rm("slow", r, 5, 1'b1);
        if (r >= 0) begin
            while (n < r + 27) cyc();
            check_frame("slow", 4'h5, r, 3, 2, 1'b1);
            dc = 0;
            for (int i = r + 1; i < n; i++) if (rm2_log[i] === 1'b1) dc++;
            chk("slow_rm_count", dc, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifotx.md
# fifotx

Frame serializer that sits directly downstream of the single-clock FIFO `fifosc`. It drains one word at a time through the FIFO's `remove`/`empty`/`do` interface and shifts each word out on a single asynchronous-serial line. Each frame is one start bit, `DATA_WIDTH` data bits LSB first, then `STOP_BITS` stop bits, with a fixed integer clocks-per-bit divider. It is the transmit half of the sandbox serial link and turns FIFO buffering into a paced wire protocol.

## Interface
- `DATA_WIDTH`, 4, word width; must equal the upstream FIFO's `DATA_WIDTH`.
- `CLKS_PER_BIT`, 4, `clk` cycles per serial bit; must be >= 2.
- `STOP_BITS`, 1, stop bits per frame; legal values are 1 or 2.
- `clk`  input  1  posedge clock, shared with the upstream FIFO.
- `flush`  input  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- `enable`  input  1  when high, new frames may start; never aborts a frame in progress.
- `empty`  input  1  FIFO empty flag.
- `fifo_do`  input  DATA_WIDTH  FIFO read data; valid the cycle after `remove` is accepted.
- `remove`  output  1  FIFO pop request; combinational, one cycle wide per word.
- `txd`  output  1  serial line, registered; idles high.
- `busy`  output  1  registered; high from LOAD through the end of the last stop bit.
- `done`  output  1  registered; one-cycle pulse in the final cycle of the last stop bit.

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- Reset (`flush` high) sets state IDLE, `txd`=1, `busy`=0, `done`=0, and clears the bit counter, baud counter and shift register. `flush` has priority over all other inputs. `remove` is 0 in any cycle where `flush` is high.
- `remove` = (state==IDLE) && `enable` && !`empty` && !`flush`. It is never asserted in any other state.
- IDLE -> LOAD on the edge where `remove`=1.
- LOAD: capture `fifo_do` into the shift register, load the baud counter with 0, then go to START. `txd` becomes 0 and `busy` becomes 1 on the same edge.
- START: hold `txd`=0 for `CLKS_PER_BIT` cycles, then enter DATA. `txd` takes shift[0] and the bit counter is cleared.
- DATA: each bit is held `CLKS_PER_BIT` cycles. At the end of each bit, shift right and increment the bit counter. After bit `DATA_WIDTH`-1, enter STOP with `txd`=1.
- STOP: hold `txd`=1 for `STOP_BITS`*`CLKS_PER_BIT` cycles. `done`=1 in the final cycle. On the next edge go to IDLE with `busy`=0.
- Baud counter width is clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. Bit counter width is clog2(`DATA_WIDTH`+1).
- Dropping `enable` mid-frame completes the frame; the block then stays in IDLE.
- A `flush` mid-frame aborts it, and `txd`=1 from the next cycle. The popped word is lost; the upstream FIFO is expected to be flushed by the same signal.

## Timing
- Cycle T: IDLE, `remove`=1. T+1: LOAD, `fifo_do` valid. T+2: first cycle of `txd`=0.
- Frame length on the line is (1+`DATA_WIDTH`+`STOP_BITS`)*`CLKS_PER_BIT` cycles. With defaults this is 24.
- Back-to-back words: IDLE and LOAD add 2 extra `txd`=1 cycles after the stop bits. The minimum word period is frame length + 2 (26 with defaults).
- `empty` is sampled only in IDLE. A word inserted during a frame is popped in the first IDLE cycle after that frame.
- `done` and `busy` fall edges are coincident: `done` in the last STOP cycle, `busy`=0 the cycle after.

## Test plan
- Flush, then idle 10 cycles with `empty`=1 -> `txd`=1, `busy`=0, `done`=0, `remove` never asserted.
- Defaults, single word 0xA -> one `remove` pulse. Two cycles later, `txd` holds 0,0,1,0,1,1, each for 4 cycles (start, data LSB-first, stop). One `done` pulse at frame cycle 24.
- Three words 0x1, 0xF, 0x6 preloaded -> three `remove` pulses exactly 26 cycles apart. Serial data decodes to 0x1, 0xF, 0x6. `busy` drops for exactly 2 cycles between frames.
- Word pending, `enable` cleared 5 cycles into a frame -> the current frame completes intact. No further `remove` until `enable` returns high.
- `flush` asserted during DATA bit 2 -> next cycle `txd`=1 and `busy`=0, with no `done` pulse. A new word after `flush` drops transmits a clean full frame.
- `STOP_BITS`=2, `CLKS_PER_BIT`=3, word 0x5 -> line reads 0,1,0,1,0,1,1, each bit 3 cycles. Frame is 21 cycles; `done` fires on cycle 21.
